// File: rtl/run_sequencer.sv
// Run controller: launches a program at its entry address, enables execution,
// and ends the run on a HALT word or when the executed-cycle limit is reached.
module run_sequencer #(
  parameter int unsigned           PC_W       = 8,
  parameter int unsigned           INSTR_W    = 9,
  parameter logic [INSTR_W-1:0]    HALT_WORD  = 9'h1FF,
  parameter logic [PC_W-1:0]       PROG0_ADDR = 8'd0,
  parameter logic [PC_W-1:0]       PROG1_ADDR = 8'd64,
  parameter logic [PC_W-1:0]       PROG2_ADDR = 8'd128,
  parameter logic [PC_W-1:0]       PROG3_ADDR = 8'd192,
  parameter int unsigned           CNT_W      = 16,
  parameter int unsigned           MAX_CYCLES = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         prog_sel,
  input  logic [INSTR_W-1:0] instruction,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_val,
  output logic               cpu_en,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_count
);

  // state | meaning
  // IDLE  | waiting for a start edge (reset state)
  // LOAD  | one cycle: PC takes the entry address, counters cleared
  // RUN   | executing; ends on HALT or on the cycle limit
  // DONE  | result held; a new start edge relaunches
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_CYCLES);

  state_t            state_q;
  logic              start_q;
  logic              pc_load_q;
  logic [PC_W-1:0]   pc_load_val_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  cycle_count_q;

  logic              accept_d;
  logic              is_halt_d;
  logic [CNT_W:0]    count_inc_d;
  logic [PC_W-1:0]   entry_addr_d;

  assign accept_d    = start & ~start_q;
  assign is_halt_d   = (instruction == HALT_WORD);
  assign count_inc_d = {1'b0, cycle_count_q} + (CNT_W+1)'(1);

  always_comb begin
    entry_addr_d = PROG0_ADDR;
    case (prog_sel)
      2'd0:    entry_addr_d = PROG0_ADDR;
      2'd1:    entry_addr_d = PROG1_ADDR;
      2'd2:    entry_addr_d = PROG2_ADDR;
      default: entry_addr_d = PROG3_ADDR;
    endcase
  end

  // start_q resets high so a start held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b1;
      pc_load_q     <= 1'b0;
      pc_load_val_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      start_q   <= start;
      pc_load_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_d) begin
            state_q       <= S_LOAD;
            pc_load_val_q <= entry_addr_d;
            pc_load_q     <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
          end
        end
        S_LOAD: begin
          state_q       <= S_RUN;
          timeout_q     <= 1'b0;
          cycle_count_q <= '0;
        end
        S_RUN: begin
          // HALT wins over the limit and is never counted as executed.
          if (is_halt_d) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b0;
          end else begin
            cycle_count_q <= count_inc_d[CNT_W-1:0];
            if (count_inc_d == MAX_C) begin
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_en      = (state_q == S_RUN) && !is_halt_d;
  assign pc_load     = pc_load_q;
  assign pc_load_val = pc_load_val_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer: stimulus pushes expected load/result
// records, a negedge monitor pops and compares them as the DUT presents them.
module tb_run_sequencer;

  localparam int          MAX  = 8;
  localparam logic [8:0]  HALT = 9'h1FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b1;
  logic [1:0]  prog_sel = 2'd0;
  logic [8:0]  instruction = 9'd0;
  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic        cpu_en;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] addr;
    int         cnt;
    bit         to;
  } res_t;

  logic [7:0] load_q[$];
  res_t       res_q[$];
  int         en_cnt = 0;
  bit         prev_done = 1'b0;
  logic [7:0] mon_addr;
  res_t       mon_res;

  run_sequencer #(.MAX_CYCLES(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_sel(prog_sel),
    .instruction(instruction), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .cpu_en(cpu_en), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] entry(input int sel);
    return 8'(sel * 64);
  endfunction

  // A run executes every non-HALT word until either HALT appears or MAX
  // words have executed, whichever comes first.
  function automatic res_t model(input int sel, input int n, input bit halt);
    res_t r;
    r.addr = entry(sel);
    if (halt && n < MAX) begin
      r.cnt = n;
      r.to  = 1'b0;
    end else begin
      r.cnt = MAX;
      r.to  = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [8:0] rand_word();
    return 9'($urandom_range(0, 510));
  endfunction

  always @(negedge clk) begin
    if (cpu_en) en_cnt++;
    if (pc_load) begin
      chk("pc_load_expected", (load_q.size() != 0), 1);
      if (load_q.size() != 0) begin
        mon_addr = load_q.pop_front();
        chk("pc_load_val", pc_load_val, mon_addr);
        chk("load_count_clr", cycle_count, 0);
        chk("load_timeout_clr", timeout, 0);
        chk("load_done_low", done, 0);
        chk("load_busy", busy, 1);
      end
      en_cnt = 0;
    end
    if (done && !prev_done) begin
      chk("done_expected", (res_q.size() != 0), 1);
      if (res_q.size() != 0) begin
        mon_res = res_q.pop_front();
        chk("cycle_count", cycle_count, mon_res.cnt);
        chk("timeout", timeout, mon_res.to);
        chk("cpu_en_cycles", en_cnt, mon_res.cnt);
        chk("pc_load_val_held", pc_load_val, mon_res.addr);
        chk("done_busy_low", busy, 0);
      end
    end
    prev_done = done;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc_load"}, pc_load, 0);
    chk({tag, "_pc_load_val"}, pc_load_val, 0);
    chk({tag, "_cpu_en"}, cpu_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // poke_at: run cycle that raises start (prog_sel=3) mid-run.
  // rst_at: run cycle that pulses reset, abandoning the run.
  task automatic do_run(input int sel, input int n, input bit halt,
                        input int poke_at, input int rst_at);
    bit finished;
    finished = 1'b0;
    load_q.push_back(entry(sel));
    if (rst_at < 0) res_q.push_back(model(sel, n, halt));
    prog_sel = 2'(sel);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_latency", pc_load, 1);
    @(posedge clk); #1;
    chk("run_pc_load_low", pc_load, 0);
    chk("run_busy", busy, 1);
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        finished = 1'b1;
        break;
      end
      instruction = (halt && i >= n) ? HALT : rand_word();
      if (i == poke_at) begin
        prog_sel = 2'd3;
        start = 1'b1;
      end
      if (i == poke_at + 1) start = 1'b0;
      if (i == rst_at) begin
        chk("pre_reset_count", cycle_count, i);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrun_reset");
        rst_n = 1'b1;
        start = 1'b0;
        instruction = rand_word();
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk("run_finished", finished, 1);
    start = 1'b0;
    instruction = rand_word();
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("held_start_idle_busy", busy, 0);
      chk("held_start_idle_done", done, 0);
      chk("held_start_no_load", pc_load, 0);
    end
    start = 1'b0;
    @(posedge clk); #1;

    do_run(2, 4, 1'b1, -1, -1);
    do_run(0, 0, 1'b0, -1, -1);
    do_run(1, 7, 1'b1, -1, -1);
    do_run(3, 6, 1'b1, 2, -1);
    do_run(0, 6, 1'b1, 1, -1);
    do_run(1, 0, 1'b1, -1, -1);
    do_run(2, 8, 1'b1, -1, -1);
    do_run(1, 5, 1'b1, -1, 3);
    do_run(1, 3, 1'b1, -1, -1);

    for (int k = 0; k < 14; k++) begin
      do_run($urandom_range(0, 3), $urandom_range(0, 11),
             ($urandom_range(0, 3) != 0), -1, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", load_q.size() + res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
